fifo_sc: RTL and testbench

FIFO_SC -- requirements
Module: fifo_sc

---
 rtl/dpram_sc.sv | 30 +++
 rtl/fifo_sc.sv | 74 +++++++
 tb/tb_fifo_sc.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/dpram_sc.sv
// Single-clock dual-port RAM: synchronous write, combinational (show-ahead) read.
// Contents are intentionally not reset.
module dpram_sc #(
  parameter int aw = 2,
  parameter int dw = 8
) (
  input  logic          ck,
  input  logic          wr,
  input  logic [aw-1:0] wa,
  input  logic [dw-1:0] di,
  input  logic          rd,
  input  logic [aw-1:0] ra,
  output logic [dw-1:0] dq
);

  localparam int depth = 2**aw;

  logic [dw-1:0] mem [depth];

  // Read data is combinational, so the read strobe carries no information here.
  logic unused_rd;
  assign unused_rd = rd;

  always_ff @(posedge ck) begin
    if (wr) mem[wa] <= di;
  end

  assign dq = mem[ra];

endmodule

// File: rtl/fifo_sc.sv
// Single-clock show-ahead FIFO with wrap-bit pointers, registered count/flags
// and sticky overflow/underflow indicators.
module fifo_sc #(
  parameter int aw = 2,
  parameter int dw = 8
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr,
  input  logic [dw-1:0] di,
  input  logic          rd,
  output logic [dw-1:0] dq,
  output logic          full,
  output logic          empty,
  output logic [aw:0]   cnt,
  output logic          ovf,
  output logic          udf
);

  localparam int depth = 2**aw;

  logic [aw:0] wp, rp, cnt_nxt;
  logic        wa_ok, rd_ok;

  // clr suppresses both requests so storage and pointers stay untouched by them.
  assign rd_ok = rd & ~empty & ~clr;
  assign wa_ok = wr & ~clr & (~full | rd_ok);

  always_comb begin
    cnt_nxt = cnt;
    if (wa_ok && !rd_ok)      cnt_nxt = cnt + 1'b1;
    else if (rd_ok && !wa_ok) cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else if (clr) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (wa_ok) wp <= wp + 1'b1;
      if (rd_ok) rp <= rp + 1'b1;
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == (aw+1)'(depth));
      empty <= (cnt_nxt == '0);
      if (wr && full && !rd_ok) ovf <= 1'b1;
      if (rd && empty)          udf <= 1'b1;
    end
  end

  dpram_sc #(.aw(aw), .dw(dw)) u_ram (
    .ck (ck),
    .wr (wa_ok),
    .wa (wp[aw-1:0]),
    .di (di),
    .rd (rd_ok),
    .ra (rp[aw-1:0]),
    .dq (dq)
  );

endmodule

// File: tb/tb_fifo_sc.sv
// Directed self-checking bench for fifo_sc (aw=2, dw=8).
module tb_fifo_sc;

  logic       ck = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] di = '0;
  logic [7:0] dq;
  logic       full, empty, ovf, udf;
  logic [2:0] cnt;

  int n_chk  = 0;
  int n_fail = 0;

  fifo_sc #(.aw(2), .dw(8)) dut (
    .ck(ck), .rst_n(rst_n), .clr(clr), .wr(wr), .di(di), .rd(rd),
    .dq(dq), .full(full), .empty(empty), .cnt(cnt), .ovf(ovf), .udf(udf)
  );

  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given request pattern; returns 1 time unit after the edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr = w; di = d; rd = r; clr = c;
    @(posedge ck);
    #1;
    wr = 1'b0; rd = 1'b0; clr = 1'b0;
  endtask

  task automatic fill4();
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b0);
  endtask

  logic [7:0] exp4 [4];

  initial begin
    // reset state
    #12;
    chk("rst_empty", empty, 1);
    chk("rst_full",  full,  0);
    chk("rst_cnt",   cnt,   0);
    chk("rst_ovf",   ovf,   0);
    chk("rst_udf",   udf,   0);
    rst_n = 1'b1;
    @(posedge ck); #1;

    // fill then drain in order
    fill4();
    chk("fill_full", full, 1);
    chk("fill_cnt",  cnt,  4);
    exp4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_dq%0d", i), dq, exp4[i]);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_empty", empty, 1);
    chk("drain_cnt",   cnt,   0);

    // write while full is rejected and flagged
    fill4();
    step(1'b1, 8'h55, 1'b0, 1'b0);
    chk("ovf_set", ovf, 1);
    chk("ovf_cnt", cnt, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_dq%0d", i), dq, exp4[i]);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("ovf_empty", empty, 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf", ovf, 0);

    // simultaneous write and read while full
    fill4();
    step(1'b1, 8'h66, 1'b1, 1'b0);
    chk("wrrd_full_cnt", cnt, 4);
    chk("wrrd_full",     full, 1);
    exp4 = '{8'h22, 8'h33, 8'h44, 8'h66};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wrrd_dq%0d", i), dq, exp4[i]);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("wrrd_empty", empty, 1);
    chk("pre_udf", udf, 0);

    // simultaneous write and read while empty
    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("empty_wrrd_udf",   udf,   1);
    chk("empty_wrrd_cnt",   cnt,   1);
    chk("empty_wrrd_empty", empty, 0);
    chk("empty_wrrd_dq",    dq,    8'h77);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_udf", udf, 0);
    chk("clr_cnt", cnt, 0);

    // interleaved pairs at depth 1, pointers wrap repeatedly
    step(1'b1, 8'ha0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("pair_dq%0d", i), dq, 8'(8'ha0 + i));
      step(1'b1, 8'(8'ha1 + i), 1'b1, 1'b0);
      chk($sformatf("pair_cnt%0d", i), cnt, 1);
    end
    chk("pair_last_dq", dq, 8'haa);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pair_empty", empty, 1);

    // async reset mid-cycle discards contents and sticky flags
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_rst_udf", udf, 1);
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b1, 8'h03, 1'b0, 1'b0);
    chk("pre_rst_cnt", cnt, 3);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_empty", empty, 1);
    chk("arst_cnt",   cnt,   0);
    chk("arst_udf",   udf,   0);
    chk("arst_ovf",   ovf,   0);
    #2 rst_n = 1'b1;
    @(posedge ck); #1;
    step(1'b1, 8'h5a, 1'b0, 1'b0);
    step(1'b1, 8'ha5, 1'b0, 1'b0);
    chk("post_rst_cnt", cnt, 2);
    chk("post_rst_dq0", dq, 8'h5a);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_dq1", dq, 8'ha5);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_empty", empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
